// File: rtl/bg_pkg.sv
// Shared definitions for the background-removal controller and its PE interface:
// one-hot state encoding, default sizing and a constant log2 helper.
package bg_pkg;

  localparam int unsigned NUM_STATES     = 9;
  localparam int unsigned NUM_PIXELS_DEF = 4;
  localparam int unsigned TIMEOUT_DEF    = 1024;
  localparam int unsigned EXP_W          = 8;
  localparam int unsigned BUSY_W         = 16;

  // One-hot state vector, one bit per state, matching the PE's flag-per-state style
  typedef enum logic [NUM_STATES-1:0] {
    ST_IDLE     = 9'b0_0000_0001,
    ST_SUM_REQ  = 9'b0_0000_0010,
    ST_SUM_WAIT = 9'b0_0000_0100,
    ST_SUM_ACK  = 9'b0_0000_1000,
    ST_BG_REQ   = 9'b0_0001_0000,
    ST_BG_WAIT  = 9'b0_0010_0000,
    ST_BG_ACK   = 9'b0_0100_0000,
    ST_DONE     = 9'b0_1000_0000,
    ST_ERR      = 9'b1_0000_0000
  } state_e;

  // Floor log2; exact for the power-of-two pixel counts used here
  function automatic int unsigned log2_f(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((n >> i) != 0) r = 32'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/bg_timer.sv
// Clearable up-counter used as the PE wait watchdog; tc_c flags the last
// count before timeout.
module bg_timer
  import bg_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_c = (cnt_q == LAST);

endmodule

// File: rtl/bg_ctrl.sv
// Background-removal controller: drives a PE through a sum pass then a
// bg-removal pass, latches the expected background colour and traps PE timeouts.
module bg_ctrl
  import bg_pkg::*;
#(
  parameter int unsigned NUM_PIXELS = NUM_PIXELS_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Start,
  input  logic                          Host_Ack,
  input  logic                          Qsd,
  input  logic                          Qbgd,
  input  logic [EXP_W*NUM_PIXELS-1:0]   red_sum,
  input  logic [EXP_W*NUM_PIXELS-1:0]   green_sum,
  input  logic [EXP_W*NUM_PIXELS-1:0]   blue_sum,
  output logic                          Start_Sum,
  output logic                          Start_BgRemoval,
  output logic                          Pe_Ack,
  output logic [EXP_W-1:0]              red_exp,
  output logic [EXP_W-1:0]              green_exp,
  output logic [EXP_W-1:0]              blue_exp,
  output logic                          Done,
  output logic                          Err,
  output logic [BUSY_W-1:0]             Busy_Cycles,
  output logic [NUM_STATES-1:0]         State
);

  localparam int unsigned SHIFT = log2_f(NUM_PIXELS);

  state_e state_q, state_d;

  logic tmr_clr, tmr_en, tmr_tc_c, cap_en;

  logic start_sum_q, start_sum_d;
  logic start_bg_q,  start_bg_d;
  logic pe_ack_q,    pe_ack_d;
  logic done_q,      done_d;
  logic err_q,       err_d;

  logic [EXP_W-1:0]  red_exp_q,   red_exp_d;
  logic [EXP_W-1:0]  green_exp_q, green_exp_d;
  logic [EXP_W-1:0]  blue_exp_q,  blue_exp_d;
  logic [BUSY_W-1:0] busy_q,      busy_d;

  bg_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .tc_c  (tmr_tc_c)
  );

  // Next-state logic; a done flag wins over the watchdog in the same cycle
  always_comb begin
    state_d = state_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    cap_en  = 1'b0;
    unique case (state_q)
      ST_IDLE:     if (Start) state_d = ST_SUM_REQ;
      ST_SUM_REQ: begin
        tmr_clr = 1'b1;
        state_d = ST_SUM_WAIT;
      end
      ST_SUM_WAIT: begin
        tmr_en = 1'b1;
        if (Qsd) begin
          cap_en  = 1'b1;
          state_d = ST_SUM_ACK;
        end else if (tmr_tc_c) begin
          state_d = ST_ERR;
        end
      end
      ST_SUM_ACK:  if (!Qsd) state_d = ST_BG_REQ;
      ST_BG_REQ: begin
        tmr_clr = 1'b1;
        state_d = ST_BG_WAIT;
      end
      ST_BG_WAIT: begin
        tmr_en = 1'b1;
        if (Qbgd)          state_d = ST_BG_ACK;
        else if (tmr_tc_c) state_d = ST_ERR;
      end
      ST_BG_ACK:   if (!Qbgd) state_d = ST_DONE;
      ST_DONE,
      ST_ERR:      if (Host_Ack) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with State
  always_comb begin
    start_sum_d = (state_d == ST_SUM_REQ);
    start_bg_d  = (state_d == ST_BG_REQ);
    pe_ack_d    = (state_d == ST_SUM_ACK) || (state_d == ST_BG_ACK);
    done_d      = (state_d == ST_DONE);
    err_d       = (state_d == ST_ERR);

    red_exp_d   = red_exp_q;
    green_exp_d = green_exp_q;
    blue_exp_d  = blue_exp_q;
    if (cap_en) begin
      red_exp_d   = EXP_W'(red_sum   >> SHIFT);
      green_exp_d = EXP_W'(green_sum >> SHIFT);
      blue_exp_d  = EXP_W'(blue_sum  >> SHIFT);
    end

    busy_d = busy_q;
    if (state_q == ST_IDLE) begin
      if (Start) busy_d = '0;
    end else if ((state_q != ST_DONE) && (state_q != ST_ERR) && (busy_q != '1)) begin
      busy_d = busy_q + BUSY_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      start_sum_q <= 1'b0;
      start_bg_q  <= 1'b0;
      pe_ack_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      red_exp_q   <= '0;
      green_exp_q <= '0;
      blue_exp_q  <= '0;
      busy_q      <= '0;
    end else begin
      state_q     <= state_d;
      start_sum_q <= start_sum_d;
      start_bg_q  <= start_bg_d;
      pe_ack_q    <= pe_ack_d;
      done_q      <= done_d;
      err_q       <= err_d;
      red_exp_q   <= red_exp_d;
      green_exp_q <= green_exp_d;
      blue_exp_q  <= blue_exp_d;
      busy_q      <= busy_d;
    end
  end

  assign Start_Sum       = start_sum_q;
  assign Start_BgRemoval = start_bg_q;
  assign Pe_Ack          = pe_ack_q;
  assign Done            = done_q;
  assign Err             = err_q;
  assign red_exp         = red_exp_q;
  assign green_exp       = green_exp_q;
  assign blue_exp        = blue_exp_q;
  assign Busy_Cycles     = busy_q;
  assign State           = state_q;

endmodule
